// File: rtl/cpu_core_if.sv
// Harvard bus bundle between cpu_core and its program ROM, data RAM and board IO.
// The core side uses the master modport; the board/memory side uses slave.
interface cpu_core_if;
  logic [15:0] instruction;
  logic [8:0]  instruction_addr;
  logic [7:0]  mem_load;
  logic        mem_en_store;
  logic        mem_en_load;
  logic [7:0]  mem_store;
  logic [9:0]  mem_addr;
  logic [7:0]  io_input;
  logic [7:0]  io_output;

  modport master (
    input  instruction, mem_load, io_input,
    output instruction_addr, mem_en_store, mem_en_load, mem_store, mem_addr, io_output
  );

  modport slave (
    output instruction, mem_load, io_input,
    input  instruction_addr, mem_en_store, mem_en_load, mem_store, mem_addr, io_output
  );
endinterface

// File: rtl/cpu_core.sv
// Single-cycle 8-bit Harvard core: four registers, 9-bit PC, combinational ROM/RAM reads.
// Every instruction retires on the rising edge that ends its fetch cycle.
module cpu_core (
  input  logic       clk,
  input  logic       rst,
  cpu_core_if.master bus
);

  typedef enum logic [3:0] {
    OP_MOV = 4'h0, OP_LDI = 4'h1, OP_LD  = 4'h2, OP_ST  = 4'h3,
    OP_ADD = 4'h4, OP_SUB = 4'h5, OP_AND = 4'h6, OP_OR  = 4'h7,
    OP_XOR = 4'h8, OP_SHL = 4'h9, OP_SHR = 4'hA, OP_IN  = 4'hB,
    OP_OUT = 4'hC, OP_JMP = 4'hD, OP_JZ  = 4'hE, OP_JNZ = 4'hF
  } opcode_e;

  opcode_e     op_s;
  logic [1:0]  ra_s;
  logic [1:0]  rb_s;
  logic [7:0]  imm_s;
  logic [9:0]  addr_s;
  logic [8:0]  tgt_s;
  logic [2:0]  sh_s;

  logic [8:0]  pc_r;
  logic [8:0]  pc_seq_s;
  logic [8:0]  pc_next_s;
  logic [7:0]  regs_r [4];
  logic [7:0]  io_out_r;

  logic [7:0]  ra_val_s;
  logic [7:0]  rb_val_s;
  logic [7:0]  wr_data_s;
  logic        wr_en_s;
  logic        out_en_s;
  logic        ld_s;
  logic        st_s;

  assign op_s     = opcode_e'(bus.instruction[15:12]);
  assign ra_s     = bus.instruction[11:10];
  assign rb_s     = bus.instruction[9:8];
  assign imm_s    = bus.instruction[7:0];
  assign addr_s   = bus.instruction[9:0];
  assign tgt_s    = bus.instruction[8:0];
  assign sh_s     = bus.instruction[2:0];

  assign ra_val_s = regs_r[ra_s];
  assign rb_val_s = regs_r[rb_s];
  assign pc_seq_s = pc_r + 9'd1;

  // Decode and execute: register write-back value, next PC and memory strobes.
  always_comb begin
    wr_en_s   = 1'b0;
    wr_data_s = 8'h00;
    out_en_s  = 1'b0;
    ld_s      = 1'b0;
    st_s      = 1'b0;
    pc_next_s = pc_seq_s;
    case (op_s)
      OP_MOV: begin wr_en_s = 1'b1; wr_data_s = rb_val_s;               end
      OP_LDI: begin wr_en_s = 1'b1; wr_data_s = imm_s;                  end
      OP_LD:  begin wr_en_s = 1'b1; wr_data_s = bus.mem_load; ld_s = 1'b1; end
      OP_ST:  begin st_s    = 1'b1;                                     end
      OP_ADD: begin wr_en_s = 1'b1; wr_data_s = ra_val_s + rb_val_s;    end
      OP_SUB: begin wr_en_s = 1'b1; wr_data_s = ra_val_s - rb_val_s;    end
      OP_AND: begin wr_en_s = 1'b1; wr_data_s = ra_val_s & rb_val_s;    end
      OP_OR:  begin wr_en_s = 1'b1; wr_data_s = ra_val_s | rb_val_s;    end
      OP_XOR: begin wr_en_s = 1'b1; wr_data_s = ra_val_s ^ rb_val_s;    end
      OP_SHL: begin wr_en_s = 1'b1; wr_data_s = ra_val_s << sh_s;       end
      OP_SHR: begin wr_en_s = 1'b1; wr_data_s = ra_val_s >> sh_s;       end
      OP_IN:  begin wr_en_s = 1'b1; wr_data_s = bus.io_input;           end
      OP_OUT: begin out_en_s = 1'b1;                                    end
      OP_JMP: begin pc_next_s = tgt_s;                                  end
      OP_JZ: begin
        if (ra_val_s == 8'h00) pc_next_s = tgt_s;
        else                   pc_next_s = pc_seq_s;
      end
      OP_JNZ: begin
        if (ra_val_s != 8'h00) pc_next_s = tgt_s;
        else                   pc_next_s = pc_seq_s;
      end
      default: begin
        wr_en_s   = 1'b0;
        pc_next_s = pc_seq_s;
      end
    endcase
  end

  // RAM strobes are gated by reset so an aborted ST never reaches the array.
  assign bus.mem_en_load      = rst & ld_s;
  assign bus.mem_en_store     = rst & st_s;
  assign bus.mem_addr         = (ld_s | st_s) ? addr_s : 10'h000;
  assign bus.mem_store        = st_s ? ra_val_s : 8'h00;
  assign bus.instruction_addr = pc_r;
  assign bus.io_output        = io_out_r;

  // Architectural state; asserting reset discards whatever instruction is in flight.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      pc_r     <= 9'd0;
      io_out_r <= 8'h00;
      for (int i = 0; i < 4; i++) begin
        regs_r[i] <= 8'h00;
      end
    end else begin
      pc_r <= pc_next_s;
      if (wr_en_s) begin
        regs_r[ra_s] <= wr_data_s;
      end
      if (out_en_s) begin
        io_out_r <= ra_val_s;
      end
    end
  end

endmodule

// File: tb/tb_cpu_core.sv
// Self-checking bench for cpu_core: directed programs plus random programs,
// compared against an instruction-level model of the architecture.
module tb_cpu_core;

  logic        clk;
  logic        rst;
  cpu_core_if  bus ();

  logic [15:0] rom [512];
  logic [7:0]  ram [1024];

  int m_pc;
  int m_out;
  int m_r   [4];
  int m_ram [1024];

  int n_checks = 0;
  int n_fails  = 0;

  cpu_core u_dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.master)
  );

  assign bus.instruction = rom[bus.instruction_addr];
  assign bus.mem_load    = ram[bus.mem_addr];

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fails++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [15:0] i_rr(input int op, input int a, input int b);
    return {op[3:0], a[1:0], b[1:0], 8'h00};
  endfunction

  function automatic logic [15:0] i_ri(input int op, input int a, input int imm);
    return {op[3:0], a[1:0], 2'b00, imm[7:0]};
  endfunction

  function automatic logic [15:0] i_ra(input int op, input int a, input int addr);
    return {op[3:0], a[1:0], addr[9:0]};
  endfunction

  function automatic logic [15:0] i_j(input int op, input int a, input int tgt);
    return {op[3:0], a[1:0], 1'b0, tgt[8:0]};
  endfunction

  task automatic model_reset();
    m_pc  = 0;
    m_out = 0;
    for (int i = 0; i < 4; i++) m_r[i] = 0;
  endtask

  // Architectural meaning of one instruction, in plain integer arithmetic.
  task automatic model_step(input logic [15:0] ins, input int din);
    int op, a, b, nxt, sh, adr, tgt;
    op  = int'(ins[15:12]);
    a   = int'(ins[11:10]);
    b   = int'(ins[9:8]);
    sh  = int'(ins[2:0]);
    adr = int'(ins[9:0]);
    tgt = int'(ins[8:0]);
    nxt = (m_pc + 1) % 512;
    case (op)
      0:  m_r[a] = m_r[b];
      1:  m_r[a] = int'(ins[7:0]);
      2:  m_r[a] = m_ram[adr];
      3:  m_ram[adr] = m_r[a];
      4:  m_r[a] = (m_r[a] + m_r[b]) % 256;
      5:  m_r[a] = (m_r[a] - m_r[b] + 256) % 256;
      6:  m_r[a] = m_r[a] & m_r[b];
      7:  m_r[a] = m_r[a] | m_r[b];
      8:  m_r[a] = m_r[a] ^ m_r[b];
      9:  m_r[a] = (m_r[a] * (1 << sh)) % 256;
      10: m_r[a] = m_r[a] / (1 << sh);
      11: m_r[a] = din;
      12: m_out  = m_r[a];
      13: nxt = tgt;
      14: if (m_r[a] == 0) nxt = tgt;
      15: if (m_r[a] != 0) nxt = tgt;
      default: ;
    endcase
    m_pc = nxt;
  endtask

  // One rising edge as seen by the RAM: commit whatever store is strobed just before it.
  task automatic edge_ram();
    logic       st;
    logic [9:0] adr;
    logic [7:0] dat;
    st  = bus.mem_en_store;
    adr = bus.mem_addr;
    dat = bus.mem_store;
    @(posedge clk);
    if (st === 1'b1) ram[adr] = dat;
  endtask

  task automatic tick();
    logic [15:0] ins;
    int op, a;
    #1;
    ins = rom[m_pc[8:0]];
    op  = int'(ins[15:12]);
    a   = int'(ins[11:10]);
    check("pc",       32'(bus.instruction_addr), 32'(m_pc));
    check("en_store", 32'(bus.mem_en_store), 32'(op == 3));
    check("en_load",  32'(bus.mem_en_load),  32'(op == 2));
    check("mem_addr", 32'(bus.mem_addr),  (op == 2 || op == 3) ? 32'(ins[9:0]) : 32'd0);
    check("mem_store", 32'(bus.mem_store), (op == 3) ? 32'(m_r[a]) : 32'd0);
    model_step(ins, int'(bus.io_input));
    edge_ram();
    @(negedge clk);
    check("io_output", 32'(bus.io_output), 32'(m_out));
  endtask

  task automatic do_reset();
    rst = 1'b0;
    model_reset();
    repeat (2) @(negedge clk);
    check("rst_pc",       32'(bus.instruction_addr), 32'd0);
    check("rst_io",       32'(bus.io_output), 32'd0);
    check("rst_en_store", 32'(bus.mem_en_store), 32'd0);
    check("rst_en_load",  32'(bus.mem_en_load), 32'd0);
    rst = 1'b1;
  endtask

  task automatic clear_rom();
    for (int i = 0; i < 512; i++) rom[i] = 16'h0000;
  endtask

  initial begin
    rst          = 1'b0;
    bus.io_input = 8'h00;
    clear_rom();
    for (int i = 0; i < 1024; i++) begin
      ram[i]   = 8'h00;
      m_ram[i] = 0;
    end

    // Arithmetic, memory and branch program.
    rom[0]   = i_ri(1, 0, 200);
    rom[1]   = i_ri(1, 1, 100);
    rom[2]   = i_rr(4, 0, 1);
    rom[3]   = i_rr(12, 0, 0);
    rom[4]   = i_rr(5, 1, 0);
    rom[5]   = i_rr(12, 1, 0);
    rom[6]   = i_ri(9, 1, 3);
    rom[7]   = i_rr(12, 1, 0);
    rom[8]   = i_ri(1, 2, 8'hA5);
    rom[9]   = i_ra(3, 2, 10'h3FF);
    rom[10]  = i_ra(2, 3, 10'h3FF);
    rom[11]  = i_rr(12, 3, 0);
    rom[12]  = i_ri(1, 0, 0);
    rom[13]  = i_j(14, 0, 20);
    rom[20]  = i_j(15, 0, 30);
    rom[21]  = i_j(13, 0, 511);
    rom[511] = i_ri(1, 1, 7);
    do_reset();
    tick();        check("release_pc1", 32'(bus.instruction_addr), 32'd1);
    tick();        check("release_pc2", 32'(bus.instruction_addr), 32'd2);
    repeat (2) tick(); check("add_out", 32'(bus.io_output), 32'd44);
    repeat (2) tick(); check("sub_out", 32'(bus.io_output), 32'd56);
    repeat (2) tick(); check("shl_out", 32'(bus.io_output), 32'd192);
    tick();
    #1;
    check("st_en",   32'(bus.mem_en_store), 32'd1);
    check("st_addr", 32'(bus.mem_addr), 32'h3FF);
    check("st_data", 32'(bus.mem_store), 32'hA5);
    tick();
    check("st_ram", 32'(ram[1023]), 32'hA5);
    #1;
    check("ld_en", 32'(bus.mem_en_load), 32'd1);
    repeat (2) tick(); check("ld_out", 32'(bus.io_output), 32'hA5);
    repeat (2) tick(); check("jz_taken", 32'(bus.instruction_addr), 32'd20);
    tick();        check("jnz_fall", 32'(bus.instruction_addr), 32'd21);
    tick();        check("jmp_511", 32'(bus.instruction_addr), 32'd511);
    tick();        check("pc_wrap", 32'(bus.instruction_addr), 32'd0);

    // IO counter loop.
    clear_rom();
    rom[0] = i_rr(11, 0, 0);
    rom[1] = i_rr(4, 1, 0);
    rom[2] = i_rr(12, 1, 0);
    rom[3] = i_j(13, 0, 0);
    bus.io_input = 8'd1;
    do_reset();
    repeat (4 * 4) tick();   check("cnt_4", 32'(bus.io_output), 32'd4);
    repeat (4 * 251) tick(); check("cnt_255", 32'(bus.io_output), 32'd255);
    repeat (4) tick();       check("cnt_wrap", 32'(bus.io_output), 32'd0);
    bus.io_input = 8'd3;
    repeat (4 * 2) tick();   check("cnt_step3", 32'(bus.io_output), 32'd6);

    // Reset asserted during a store.
    clear_rom();
    rom[0] = i_ri(1, 0, 8'h5A);
    rom[1] = i_ri(1, 1, 8'h33);
    rom[2] = i_ri(1, 2, 8'h44);
    rom[3] = i_ri(1, 3, 8'h55);
    rom[4] = i_rr(12, 3, 0);
    rom[5] = i_ra(3, 0, 5);
    rom[6] = i_j(13, 0, 6);
    ram[5]   = 8'h11;
    m_ram[5] = 17;
    do_reset();
    repeat (5) tick();
    #1;
    check("abort_st_seen", 32'(bus.mem_en_store), 32'd1);
    rst = 1'b0;
    #1;
    check("abort_en_store", 32'(bus.mem_en_store), 32'd0);
    check("abort_en_load",  32'(bus.mem_en_load), 32'd0);
    edge_ram();
    @(negedge clk);
    check("abort_ram", 32'(ram[5]), 32'h11);
    check("abort_pc",  32'(bus.instruction_addr), 32'd0);
    check("abort_io",  32'(bus.io_output), 32'd0);
    model_reset();
    clear_rom();
    for (int i = 0; i < 4; i++) rom[i] = i_rr(12, i, 0);
    rom[4] = i_j(13, 0, 4);
    rst = 1'b1;
    for (int i = 0; i < 4; i++) begin
      tick();
      check("reg_cleared", 32'(bus.io_output), 32'd0);
    end

    // Random programs with random input port traffic.
    for (int s = 0; s < 3; s++) begin
      int bad;
      for (int i = 0; i < 512; i++) rom[i] = 16'($urandom);
      for (int i = 0; i < 1024; i++) begin
        ram[i]   = 8'($urandom);
        m_ram[i] = int'(ram[i]);
      end
      do_reset();
      for (int c = 0; c < 200; c++) begin
        bus.io_input = 8'($urandom);
        tick();
      end
      bad = 0;
      for (int i = 0; i < 1024; i++) begin
        if (int'(ram[i]) != m_ram[i]) bad++;
      end
      check("ram_image", 32'(bad), 32'd0);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end

endmodule

// File: doc/cpu_core.md
Name: cpu_core

Overview:
- Single-cycle 8-bit accumulator-style processor core with four 8-bit general registers, a 9-bit program counter and a Harvard interface.
- Instructions are 16 bits, fetched combinationally from an external program ROM addressed by instruction_addr.
- Data lives in an external 1024x8 RAM with synchronous write and combinational read.
- One 8-bit input port and one registered 8-bit output port connect the core to the board.

Parameters:
- None. All widths are fixed: instruction 16, instruction address 9, data 8, data address 10.

Ports:
- clk  input  1  system clock; all state updates on rising edge.
- rst  input  1  asynchronous reset, active-low (asserted when 0).
- instruction  input  16  instruction word at instruction_addr, valid in the same cycle.
- mem_load  input  8  RAM read data for mem_addr, combinational, same cycle.
- mem_en_store  output  1  RAM write enable; RAM writes mem_store to mem_addr on the rising edge.
- mem_en_load  output  1  high during LD.
- mem_store  output  8  RAM write data.
- mem_addr  output  10  RAM address, shared by load and store.
- instruction_addr  output  9  program counter.
- io_input  input  8  external input port, sampled by IN.
- io_output  output  8  registered output port.

Behaviour:
Instruction format:
- op = [15:12], ra = [11:10], rb = [9:8], imm8 = [7:0], addr10 = [9:0], tgt9 = [8:0], sh3 = [2:0].
- Unused bits are ignored.

Opcodes:
- 0 MOV: ra <= rb.
- 1 LDI: ra <= imm8.
- 2 LD: ra <= mem_load; mem_addr = addr10; mem_en_load = 1.
- 3 ST: mem_store = ra; mem_addr = addr10; mem_en_store = 1.
- 4 ADD: ra <= ra + rb.
- 5 SUB: ra <= ra - rb.
- 6 AND, 7 OR, 8 XOR: ra <= ra op rb.
- 9 SHL: ra <= ra << sh3, logical.
- A SHR: ra <= ra >> sh3, logical, zero-fill.
- B IN: ra <= io_input.
- C OUT: io_output <= ra.
- D JMP: pc <= tgt9.
- E JZ: if ra == 0 then pc <= tgt9.
- F JNZ: if ra != 0 then pc <= tgt9.

Arithmetic and flow:
- All arithmetic is modulo 256. There are no flags.
- Every instruction completes in one clock. The PC otherwise advances pc+1 and wraps 511 -> 0.
- A program halts by jumping to itself.

Memory interface:
- When op is not LD/ST: mem_addr = 0, mem_store = 0, and both enables are 0.
- LD followed by ST to the same address in consecutive cycles must write the loaded value.
- ST followed by LD from the same address returns the newly stored value, because the write commits at the edge ending the ST cycle.

Reset:
- While rst = 0, asynchronously: pc = 0, r0..r3 = 0, io_output = 0.
- Enables are forced to 0 during reset.
- Reset asserted mid-program aborts the current instruction with no register or memory write.
- The first instruction executes in the first rising edge after rst rises.

IO timing:
- IN samples io_input at the rising edge ending the IN cycle.
- io_output changes only on an OUT edge and holds otherwise.

Test Plan:
- Reset: hold rst = 0 for 2 cycles -> instruction_addr = 0, io_output = 0, mem_en_store = mem_en_load = 0. Release -> instruction_addr increments 0,1,2 on successive edges.
- Arithmetic/OUT: LDI r0,200; LDI r1,100; ADD r0,r1; OUT r0 -> io_output = 44. Then SUB r1,r0; OUT r1 -> 56. SHL r1,3; OUT r1 -> 192.
- Memory: LDI r2,0xA5; ST r2,[0x3FF] -> one cycle with mem_en_store = 1, mem_addr = 0x3FF, mem_store = 0xA5. Then LD r3,[0x3FF]; OUT r3 -> mem_en_load = 1 in that cycle, io_output = 0xA5.
- Branches: LDI r0,0; JZ r0,10 -> next instruction_addr = 10. JNZ r0,20 -> falls through to 11. JMP 511; then an instruction at 511 without jump -> pc wraps to 0.
- IO counter: loop of IN r0; ADD r1,r0; OUT r1; JMP 0 with io_input = 1 -> io_output increments by 1 every 4 cycles and wraps 255 -> 0. Changing io_input to 3 -> steps of 3.
- Reset mid-run: assert rst during a ST cycle -> no write occurs (RAM content unchanged), all registers read 0 after release.
